// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. Two-flop synchroniser on the serial line,
//             start-bit validation at half a bit period, mid-bit sampling of
//             8 data bits (LSB first) and the stop bit. Good frames update
//             rx_data with a one-cycle rx_valid strobe; a low stop bit gives a
//             one-cycle rx_frame_err strobe, and the receiver then waits for
//             the line to return high before looking for a new start bit.
//  Ports    : clk          system clock
//             rst          synchronous reset, active-high
//             rx           asynchronous serial input, idles at 1
//             rx_data      last correctly received byte
//             rx_valid     one-cycle pulse when rx_data is updated
//             rx_frame_err one-cycle pulse when the stop bit is sampled low
//             rx_busy      high whenever the receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_frame_err_q, rx_frame_err_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    sync1_d        = rx;
    sync2_d        = sync1_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (cnt_q == C_HALF_LAST) begin
          cnt_d = '0;
          // Line still low at mid start bit: real start. Otherwise a glitch.
          if (!rx_s) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_DATA: begin
        // Start validation ended mid start bit, so a full period lands mid data bit.
        if (cnt_q == C_BIT_LAST) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == C_BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            rx_frame_err_d = 1'b1;
            state_d        = S_RECOVER;
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
        end
      end

      S_RECOVER: begin
        // A held-low line (break) must not be decoded as back-to-back 0x00 frames.
        if (rx_s) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_idx_q      <= 3'd0;
      shift_q        <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx, run at 16 clocks per bit.
//             Expected bytes go into a scoreboard queue as frames are driven
//             and are popped when rx_valid fires.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 62_500;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;   // 16
  localparam int HALF      = CPB / 2;                // 8
  localparam int LATENCY   = 2 + HALF + 9 * CPB;     // 154

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx_line),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         valid_cnt = 0;
  int         err_cnt = 0;
  int         pending_err = 0;
  int         last_valid_cyc = 0;
  int         start_cyc = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input bit ok, input int act, input int exp);
    total = total + 1;
    if (!ok) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Scoreboard / strobe monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && rx_frame_err) chk("strobe_exclusive", 1'b0, 1, 0);
      if (rx_valid) begin
        valid_cnt      = valid_cnt + 1;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1'b0, int'(rx_data), -1);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("rx_data", rx_data == e, int'(rx_data), int'(e));
        end
      end
      if (rx_frame_err) begin
        err_cnt = err_cnt + 1;
        chk("frame_err_expected", pending_err > 0, 1, pending_err);
        if (pending_err > 0) pending_err = pending_err - 1;
      end
    end
  end

  // Drives one 8N1 frame starting at the current negedge. The line is left at
  // the stop-bit level. rst_bit >= 0 pulses reset mid data bit and abandons.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int rst_bit);
    rx_line   = 1'b0;
    start_cyc = cyc + 1;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_line = d[i];
      if (i == rst_bit) begin
        repeat (HALF) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        rx_line = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        return;
      end
      repeat (CPB) @(negedge clk);
    end
    rx_line = stop_v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_valid(input int target, input string name);
    int budget;
    budget = 4 * CPB * 10;
    while (valid_cnt < target && budget > 0) begin
      @(negedge clk);
      budget = budget - 1;
    end
    chk(name, valid_cnt >= target, valid_cnt, target);
  endtask

  typedef struct {
    logic [7:0] data;
    int         gap;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int t0;
    int v0;
    logic [7:0] held;

    vecs[0] = '{data: 8'h5A, gap: 10};
    vecs[1] = '{data: 8'h00, gap: 0};   // back-to-back, single stop bit
    vecs[2] = '{data: 8'hFF, gap: 5};
    vecs[3] = '{data: 8'h01, gap: 0};
    vecs[4] = '{data: 8'h80, gap: 3};
    vecs[5] = '{data: 8'hA5, gap: 7};   // loopback-style pair
    vecs[6] = '{data: 8'h5A, gap: 0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data == 8'h00, int'(rx_data), 0);
    chk("reset_valid", rx_valid == 1'b0, int'(rx_valid), 0);
    chk("reset_frame_err", rx_frame_err == 1'b0, int'(rx_frame_err), 0);
    chk("reset_busy", rx_busy == 1'b0, int'(rx_busy), 0);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("idle_rx_data", rx_data == 8'h00, int'(rx_data), 0);
    chk("idle_busy", rx_busy == 1'b0, int'(rx_busy), 0);
    chk("idle_no_valid", valid_cnt == 0, valid_cnt, 0);

    // Single frame with latency check
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, -1);
    wait_valid(1, "a5_arrived");
    chk("latency", (last_valid_cyc - start_cyc >= LATENCY - 2) &&
                   (last_valid_cyc - start_cyc <= LATENCY + 2),
        last_valid_cyc - start_cyc, LATENCY);
    chk("a5_no_frame_err", err_cnt == 0, err_cnt, 0);

    // Table-driven frames
    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].gap) @(negedge clk);
      exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, 1'b1, -1);
    end
    wait_valid(8, "table_frames_arrived");
    chk("table_last_data", rx_data == 8'h5A, int'(rx_data), 8'h5A);

    // Short low glitch is rejected
    repeat (20) @(negedge clk);
    v0      = valid_cnt;
    rx_line = 1'b0;
    t0      = cyc + 1;
    repeat (5) @(negedge clk);
    rx_line = 1'b1;
    chk("glitch_busy_seen", rx_busy == 1'b1, int'(rx_busy), 1);
    while (cyc < t0 + HALF + 3) @(negedge clk);
    chk("glitch_busy_cleared", rx_busy == 1'b0, int'(rx_busy), 0);
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_no_valid", valid_cnt == v0, valid_cnt, v0);
    chk("glitch_no_err", err_cnt == 0, err_cnt, 0);

    // Framing error followed by a break, then a good frame
    held        = rx_data;
    pending_err = pending_err + 1;
    send_frame(8'hFF, 1'b0, -1);
    repeat (3 * CPB) @(negedge clk);
    chk("ferr_count", err_cnt == 1, err_cnt, 1);
    chk("ferr_data_held", rx_data == held, int'(rx_data), int'(held));
    chk("ferr_no_valid", valid_cnt == v0, valid_cnt, v0);
    chk("break_busy", rx_busy == 1'b1, int'(rx_busy), 1);
    rx_line = 1'b1;
    repeat (6) @(negedge clk);
    chk("recover_idle", rx_busy == 1'b0, int'(rx_busy), 0);
    repeat (CPB) @(negedge clk);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, -1);
    wait_valid(v0 + 1, "post_ferr_frame");

    // Reset during data bit 4, then a fresh frame
    repeat (CPB) @(negedge clk);
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1, 4);
    chk("midreset_rx_data", rx_data == 8'h00, int'(rx_data), 0);
    chk("midreset_no_valid", valid_cnt == v0, valid_cnt, v0);
    chk("midreset_busy", rx_busy == 1'b0, int'(rx_busy), 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, -1);
    wait_valid(v0 + 1, "post_reset_frame");
    chk("post_reset_data", rx_data == 8'h81, int'(rx_data), 8'h81);

    // Wrap-up
    repeat (2 * CPB) @(negedge clk);
    chk("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    chk("total_valid", valid_cnt == 10, valid_cnt, 10);
    chk("total_frame_err", err_cnt == 1, err_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
